// File: rtl/debounce_multi_pkg.sv
// Shared definitions for the multi-channel button conditioner.
//   - rpt_state_e : per-channel auto-repeat state encoding
//   - clog2_min1  : ceil(log2(value)) clamped to at least 1, used to size
//                   counters that must hold values 0 .. value-1
package debounce_multi_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_HOLD   = 2'd1,
        ST_REPEAT = 2'd2
    } rpt_state_e;

    function automatic int clog2_min1(input int value);
        int width;
        width = 0;
        for (int v = value - 1; v > 0; v = v >> 1) begin
            width++;
        end
        return (width < 1) ? 1 : width;
    endfunction

endpackage

// File: rtl/debounce_multi_channel.sv
// One channel of the button conditioner: synchroniser, stability filter,
// debounced level register, press/release pulse generation and the
// auto-repeat state machine.
// Ports:
//   clk           rising-edge clock
//   rst           synchronous active-high reset
//   sig_in        raw asynchronous button input (active-high)
//   repeat_en     enables auto-repeat press pulses while held
//   level_out     debounced level
//   press_pulse   1-cycle pulse on accepted press and on each repeat
//   release_pulse 1-cycle pulse on accepted release
module debounce_multi_channel
    import debounce_multi_pkg::*;
#(
    parameter int SYNC_STAGES   = 2,
    parameter int STABLE_CYCLES = 16,
    parameter int REPEAT_DELAY  = 50000000,
    parameter int REPEAT_PERIOD = 10000000
) (
    input  logic clk,
    input  logic rst,
    input  logic sig_in,
    input  logic repeat_en,
    output logic level_out,
    output logic press_pulse,
    output logic release_pulse
);

    localparam int CNT_W  = clog2_min1(STABLE_CYCLES);
    localparam int RMAX   = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
    localparam int RCNT_W = clog2_min1(RMAX);

    localparam logic [CNT_W-1:0]  CNT_LAST    = CNT_W'(STABLE_CYCLES - 1);
    localparam logic [RCNT_W-1:0] DELAY_LAST  = RCNT_W'(REPEAT_DELAY - 1);
    localparam logic [RCNT_W-1:0] PERIOD_LAST = RCNT_W'(REPEAT_PERIOD - 1);

    logic [SYNC_STAGES-1:0] sync_q, sync_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic [RCNT_W-1:0]      rcnt_q, rcnt_d;
    logic                   level_q, level_d;
    logic                   press_q, press_d;
    logic                   release_q, release_d;
    rpt_state_e             state_q, state_d;

    logic                   s;
    logic                   acc_press;
    logic                   acc_release;
    logic [RCNT_W-1:0]      rcnt_last;

    assign s = sync_q[SYNC_STAGES-1];

    always_comb begin
        sync_d      = {sync_q[SYNC_STAGES-2:0], sig_in};
        cnt_d       = cnt_q;
        level_d     = level_q;
        rcnt_d      = rcnt_q;
        state_d     = state_q;
        acc_press   = 1'b0;
        acc_release = 1'b0;
        rcnt_last   = (state_q == ST_HOLD) ? DELAY_LAST : PERIOD_LAST;

        // Stability filter: any sample matching the current level restarts
        // the count, so only an unbroken run of differing samples is accepted.
        if (s != level_q) begin
            if (cnt_q == CNT_LAST) begin
                level_d     = s;
                cnt_d       = '0;
                acc_press   = s;
                acc_release = ~s;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end else begin
            cnt_d = '0;
        end

        press_d   = acc_press;
        release_d = acc_release;

        case (state_q)
            ST_IDLE: begin
                if (acc_press) begin
                    state_d = ST_HOLD;
                    rcnt_d  = '0;
                end
            end
            ST_HOLD, ST_REPEAT: begin
                // Release takes priority over a coincident repeat expiry.
                if (acc_release) begin
                    state_d = ST_IDLE;
                    rcnt_d  = '0;
                end else if (!repeat_en) begin
                    rcnt_d = '0;
                end else if (rcnt_q == rcnt_last) begin
                    press_d = 1'b1;
                    rcnt_d  = '0;
                    state_d = ST_REPEAT;
                end else begin
                    rcnt_d = rcnt_q + 1'b1;
                end
            end
            default: begin
                state_d = ST_IDLE;
                rcnt_d  = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sync_q    <= '0;
            cnt_q     <= '0;
            rcnt_q    <= '0;
            level_q   <= 1'b0;
            press_q   <= 1'b0;
            release_q <= 1'b0;
            state_q   <= ST_IDLE;
        end else begin
            sync_q    <= sync_d;
            cnt_q     <= cnt_d;
            rcnt_q    <= rcnt_d;
            level_q   <= level_d;
            press_q   <= press_d;
            release_q <= release_d;
            state_q   <= state_d;
        end
    end

    assign level_out     = level_q;
    assign press_pulse   = press_q;
    assign release_pulse = release_q;

endmodule

// File: rtl/debounce_multi.sv
// Multi-channel push-button conditioner. Each channel is an independent
// debounce_multi_channel instance sharing clk, rst and repeat_en.
// Ports:
//   clk           rising-edge clock
//   rst           synchronous active-high reset
//   sig_in        [N_CH] raw asynchronous button inputs (active-high)
//   repeat_en     enables auto-repeat on all channels
//   level_out     [N_CH] debounced levels
//   press_pulse   [N_CH] 1-cycle pulses on accepted press and on each repeat
//   release_pulse [N_CH] 1-cycle pulses on accepted release
module debounce_multi
    import debounce_multi_pkg::*;
#(
    parameter int N_CH          = 4,
    parameter int SYNC_STAGES   = 2,
    parameter int STABLE_CYCLES = 16,
    parameter int REPEAT_DELAY  = 50000000,
    parameter int REPEAT_PERIOD = 10000000
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [N_CH-1:0] sig_in,
    input  logic            repeat_en,
    output logic [N_CH-1:0] level_out,
    output logic [N_CH-1:0] press_pulse,
    output logic [N_CH-1:0] release_pulse
);

    for (genvar i = 0; i < N_CH; i++) begin : g_ch
        debounce_multi_channel #(
            .SYNC_STAGES  (SYNC_STAGES),
            .STABLE_CYCLES(STABLE_CYCLES),
            .REPEAT_DELAY (REPEAT_DELAY),
            .REPEAT_PERIOD(REPEAT_PERIOD)
        ) u_ch (
            .clk          (clk),
            .rst          (rst),
            .sig_in       (sig_in[i]),
            .repeat_en    (repeat_en),
            .level_out    (level_out[i]),
            .press_pulse  (press_pulse[i]),
            .release_pulse(release_pulse[i])
        );
    end

endmodule

// File: tb/tb_debounce_multi.sv
module tb_debounce_multi;

    logic       clk = 1'b0;
    logic       rst;
    logic [1:0] sig_in;
    logic       repeat_en;
    logic [1:0] level_out;
    logic [1:0] press_pulse;
    logic [1:0] release_pulse;

    int n_cmp = 0;
    int n_err = 0;

    debounce_multi #(
        .N_CH         (2),
        .SYNC_STAGES  (2),
        .STABLE_CYCLES(4),
        .REPEAT_DELAY (10),
        .REPEAT_PERIOD(5)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .sig_in       (sig_in),
        .repeat_en    (repeat_en),
        .level_out    (level_out),
        .press_pulse  (press_pulse),
        .release_pulse(release_pulse)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [5:0] obs();
        return {level_out, press_pulse, release_pulse};
    endfunction

    // Outputs are observed as {level[1:0], press[1:0], release[1:0]}.
    task automatic test_reset();
        logic [5:0] exp;
        rst = 1'b1; sig_in = 2'b11; repeat_en = 1'b0;
        for (int k = 1; k <= 3; k++) begin
            tick();
            n_cmp++;
            if (obs() !== 6'b0) begin
                n_err++;
                $display("FAIL reset_hold cyc=%0d got=%b want=%b", k, obs(), 6'b0);
            end
        end
        rst = 1'b0;
        for (int k = 1; k <= 8; k++) begin
            tick();
            exp = {(k >= 6) ? 2'b11 : 2'b00, (k == 6) ? 2'b11 : 2'b00, 2'b00};
            n_cmp++;
            if (obs() !== exp) begin
                n_err++;
                $display("FAIL reset_rise cyc=%0d got=%b want=%b", k, obs(), exp);
            end
        end
        sig_in = 2'b00;
        for (int k = 1; k <= 8; k++) begin
            tick();
            exp = {(k >= 6) ? 2'b00 : 2'b11, 2'b00, (k == 6) ? 2'b11 : 2'b00};
            n_cmp++;
            if (obs() !== exp) begin
                n_err++;
                $display("FAIL reset_fall cyc=%0d got=%b want=%b", k, obs(), exp);
            end
        end
    endtask

    task automatic test_clean();
        logic [5:0] exp;
        sig_in = 2'b01;
        for (int k = 1; k <= 20; k++) begin
            tick();
            exp = {(k >= 6) ? 2'b01 : 2'b00, (k == 6) ? 2'b01 : 2'b00, 2'b00};
            n_cmp++;
            if (obs() !== exp) begin
                n_err++;
                $display("FAIL clean_press cyc=%0d got=%b want=%b", k, obs(), exp);
            end
        end
        sig_in = 2'b00;
        for (int k = 1; k <= 10; k++) begin
            tick();
            exp = {(k >= 6) ? 2'b00 : 2'b01, 2'b00, (k == 6) ? 2'b01 : 2'b00};
            n_cmp++;
            if (obs() !== exp) begin
                n_err++;
                $display("FAIL clean_release cyc=%0d got=%b want=%b", k, obs(), exp);
            end
        end
    endtask

    task automatic test_bounce();
        logic [4:0] pattern;
        logic [5:0] exp;
        pattern = 5'b10110;  // bit 4 first: 1,0,1,1,0 then steady 1
        for (int k = 0; k < 5; k++) begin
            sig_in = {1'b0, pattern[4-k]};
            tick();
            n_cmp++;
            if (obs() !== 6'b0) begin
                n_err++;
                $display("FAIL bounce_quiet cyc=%0d got=%b want=%b", k, obs(), 6'b0);
            end
        end
        sig_in = 2'b01;
        for (int k = 1; k <= 10; k++) begin
            tick();
            exp = {(k >= 6) ? 2'b01 : 2'b00, (k == 6) ? 2'b01 : 2'b00, 2'b00};
            n_cmp++;
            if (obs() !== exp) begin
                n_err++;
                $display("FAIL bounce_accept cyc=%0d got=%b want=%b", k, obs(), exp);
            end
        end
        sig_in = 2'b00;
        for (int k = 1; k <= 8; k++) begin
            tick();
            exp = {(k >= 6) ? 2'b00 : 2'b01, 2'b00, (k == 6) ? 2'b01 : 2'b00};
            n_cmp++;
            if (obs() !== exp) begin
                n_err++;
                $display("FAIL bounce_release cyc=%0d got=%b want=%b", k, obs(), exp);
            end
        end
    endtask

    // Three synchronised samples reach cnt==3 but never the accept edge.
    task automatic test_glitch();
        for (int k = 1; k <= 13; k++) begin
            sig_in = (k <= 3) ? 2'b10 : 2'b00;
            tick();
            n_cmp++;
            if (obs() !== 6'b0) begin
                n_err++;
                $display("FAIL glitch cyc=%0d got=%b want=%b", k, obs(), 6'b0);
            end
        end
    endtask

    // Input sampled on edge k is accepted on edge k+5. Accept at 6, repeats at
    // 16 then every 5. last_hi is the last tick with sig_in high.
    task automatic run_repeat(input int last_hi, input int rel_edge, input string tag);
        logic [5:0] exp;
        logic       p;
        repeat_en = 1'b1;
        for (int k = 1; k <= 60; k++) begin
            sig_in = (k <= last_hi) ? 2'b01 : 2'b00;
            tick();
            p = (k == 6) || ((k >= 16) && (k < rel_edge) && (((k - 16) % 5) == 0));
            exp = {(k >= 6 && k < rel_edge) ? 2'b01 : 2'b00, {1'b0, p},
                   (k == rel_edge) ? 2'b01 : 2'b00};
            n_cmp++;
            if (obs() !== exp) begin
                n_err++;
                $display("FAIL %s cyc=%0d got=%b want=%b", tag, k, obs(), exp);
            end
        end
        repeat_en = 1'b0;
    endtask

    task automatic test_repeat();
        run_repeat(44, 50, "repeat");
    endtask

    // Release accepted on edge 51, which is also a repeat expiry edge.
    task automatic test_collision();
        run_repeat(45, 51, "collision");
    endtask

    task automatic test_mid_reset();
        repeat_en = 1'b1;
        sig_in = 2'b01;
        for (int k = 1; k <= 6; k++) tick();
        n_cmp++;
        if (obs() !== 6'b010100) begin
            n_err++;
            $display("FAIL midrst_setup got=%b want=%b", obs(), 6'b010100);
        end
        sig_in = 2'b00;
        for (int k = 1; k <= 4; k++) tick();  // release count now at 2
        rst = 1'b1;
        tick();
        n_cmp++;
        if (obs() !== 6'b0) begin
            n_err++;
            $display("FAIL midrst_during got=%b want=%b", obs(), 6'b0);
        end
        rst = 1'b0;
        for (int k = 1; k <= 15; k++) begin
            tick();
            n_cmp++;
            if (obs() !== 6'b0) begin
                n_err++;
                $display("FAIL midrst_after cyc=%0d got=%b want=%b", k, obs(), 6'b0);
            end
        end
        repeat_en = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        sig_in = 2'b00;
        repeat_en = 1'b0;
        test_reset();
        test_clean();
        test_bounce();
        test_glitch();
        test_repeat();
        test_collision();
        test_mid_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
